bg_scroller: RTL and testbench

BG_SCROLLER -- requirements
Module: bg_scroller

---
 rtl/bg_pkg.sv | 31 +++
 rtl/bg_layer_acc.sv | 50 +++++
 rtl/bg_scroller.sv | 145 ++++++++++++++
 tb/tb_bg_scroller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// bg_pkg -- shared definitions for the background scroller.
//   OFS_W       : integer width of every layer offset (pixels)
//   MAX_LAYERS  : largest supported number of parallax layers
//   bg_state_e  : speed-ramp FSM state encoding
//   step_toward : move a fixed-point speed toward a goal by at most one step
package bg_pkg;

    localparam int OFS_W      = 10;
    localparam int MAX_LAYERS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        CRUISE = 2'd2,
        BRAKE  = 2'd3
    } bg_state_e;

    // Speeds are carried at 16 bits here; callers zero-extend and truncate.
    // Lands exactly on the goal when it is within one step.
    function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                                input logic [15:0] goal,
                                                input logic [15:0] step);
        logic [15:0] res;
        if (cur < goal)
            res = ((goal - cur) > step) ? cur + step : goal;
        else
            res = ((cur - goal) > step) ? cur - step : goal;
        return res;
    endfunction

endpackage

// File: rtl/bg_layer_acc.sv
// bg_layer_acc -- one axis of one parallax layer: a fixed-point position
// accumulator that moves backwards by 'speed' per step and wraps modulo
// MODULUS pixels.
//   clk, reset : clock, asynchronous active-low reset
//   step_en    : advance the accumulator this cycle (frame boundary)
//   clear      : synchronous zero, has priority over step_en
//   speed      : fixed-point step (FRAC_BITS fraction bits)
//   offset     : integer part of the accumulator, always < MODULUS
module bg_layer_acc
    import bg_pkg::*;
#(
    parameter int MODULUS    = 160,
    parameter int SPEED_IN_W = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_en,
    input  logic                  clear,
    input  logic [SPEED_IN_W-1:0] speed,
    output logic [OFS_W-1:0]      offset
);

    localparam int ACC_W  = OFS_W + FRAC_BITS;
    localparam int MOD_FX = MODULUS << FRAC_BITS;
    // One spare MSB so the subtraction result carries its own sign.
    localparam int EW     = ((SPEED_IN_W > ACC_W) ? SPEED_IN_W : ACC_W) + 1;
    localparam logic [EW-1:0] MOD_E = EW'(MOD_FX);

    logic [ACC_W-1:0] acc;
    logic [EW-1:0]    spd_ext, spd_clamp, diff, nxt;

    // Clamping below the modulus keeps a single wrap add sufficient.
    assign spd_ext   = EW'(speed);
    assign spd_clamp = (spd_ext >= MOD_E) ? MOD_E - EW'(1) : spd_ext;
    assign diff      = EW'(acc) - spd_clamp;
    assign nxt       = diff[EW-1] ? diff + MOD_E : diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (step_en)
            acc <= nxt[ACC_W-1:0];
    end

    assign offset = acc[ACC_W-1:FRAC_BITS];

endmodule

// File: rtl/bg_scroller.sv
// bg_scroller -- multi-layer parallax background scroller.
// Layer k moves at cur_speed>>k vertically and drift_x>>k horizontally,
// once per frame_end. With BG_SCROLL_RAMP_EN defined the vertical speed
// ramps toward target_speed through an IDLE/RAMP/CRUISE/BRAKE FSM; without
// it the speed is loaded directly each frame.
//   clk, reset   : clock, asynchronous active-low reset
//   frame_end    : one-cycle pulse per frame, qualifies every update
//   run          : 1 scroll toward target, 0 brake (sampled at frame_end)
//   clear        : synchronous pulse zeroing all offsets
//   target_speed : layer-0 vertical target speed (fixed point)
//   drift_x      : layer-0 horizontal speed (fixed point, no ramp)
//   offset_x/y   : per-layer offsets, layer 0 in the LSBs
//   cur_speed    : present layer-0 vertical speed
//   state        : ramp FSM state
module bg_scroller
    import bg_pkg::*;
#(
    parameter int BG_WIDTH   = 160,
    parameter int BG_HEIGHT  = 240,
    parameter int NUM_LAYERS = 2,
    parameter int SPEED_W    = 4,
    parameter int FRAC_BITS  = 4,
    parameter int RAMP_STEP  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_end,
    input  logic                          run,
    input  logic                          clear,
    input  logic [SPEED_W+FRAC_BITS-1:0]  target_speed,
    input  logic [SPEED_W+FRAC_BITS-1:0]  drift_x,
    output logic [NUM_LAYERS*OFS_W-1:0]   offset_x,
    output logic [NUM_LAYERS*OFS_W-1:0]   offset_y,
    output logic [SPEED_W+FRAC_BITS-1:0]  cur_speed,
    output logic [1:0]                    state
);

    localparam int SW = SPEED_W + FRAC_BITS;

    if (NUM_LAYERS < 1 || NUM_LAYERS > MAX_LAYERS || RAMP_STEP < 1 || SW > 16) begin : g_bad_cfg
        $error("bg_scroller: unsupported parameter combination");
    end

    bg_state_e st;
    assign state = st;

    // Layers read the registered speed, so motion lags a speed change by
    // one frame.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        logic [SW-1:0] spd_y, spd_x;
        assign spd_y = cur_speed >> k;
        assign spd_x = drift_x >> k;

        bg_layer_acc #(
            .MODULUS    (BG_HEIGHT),
            .SPEED_IN_W (SW),
            .FRAC_BITS  (FRAC_BITS)
        ) u_acc_y (
            .clk     (clk),
            .reset   (reset),
            .step_en (frame_end),
            .clear   (clear),
            .speed   (spd_y),
            .offset  (offset_y[k*OFS_W +: OFS_W])
        );

        bg_layer_acc #(
            .MODULUS    (BG_WIDTH),
            .SPEED_IN_W (SW),
            .FRAC_BITS  (FRAC_BITS)
        ) u_acc_x (
            .clk     (clk),
            .reset   (reset),
            .step_en (frame_end),
            .clear   (clear),
            .speed   (spd_x),
            .offset  (offset_x[k*OFS_W +: OFS_W])
        );
    end

    // A clear coinciding with frame_end freezes the speed FSM for that frame.
    logic fsm_en;
    assign fsm_en = frame_end && !clear;

`ifdef BG_SCROLL_RAMP_EN
    localparam logic [15:0] STEP = 16'(RAMP_STEP);

    logic [15:0] cur16, tgt16, up, dn;
    assign cur16 = 16'(cur_speed);
    assign tgt16 = 16'(target_speed);
    assign up    = step_toward(cur16, tgt16, STEP);
    assign dn    = step_toward(cur16, 16'd0, STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            cur_speed <= '0;
        end else if (fsm_en) begin
            case (st)
                IDLE: begin
                    if (run && tgt16 != 16'd0) begin
                        cur_speed <= SW'(up);
                        st        <= (up == tgt16) ? CRUISE : RAMP;
                    end
                end
                RAMP, CRUISE: begin
                    if (!run) begin
                        cur_speed <= SW'(dn);
                        st        <= (dn == 16'd0) ? IDLE : BRAKE;
                    end else if (cur16 != tgt16) begin
                        cur_speed <= SW'(up);
                        st        <= (up == tgt16) ? CRUISE : RAMP;
                    end else begin
                        st        <= CRUISE;
                    end
                end
                BRAKE: begin
                    if (run && tgt16 != 16'd0) begin
                        cur_speed <= SW'(up);
                        st        <= (up == tgt16) ? CRUISE : RAMP;
                    end else begin
                        cur_speed <= SW'(dn);
                        st        <= (dn == 16'd0) ? IDLE : BRAKE;
                    end
                end
                default: begin
                    st        <= IDLE;
                    cur_speed <= '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            cur_speed <= '0;
        end else if (fsm_en) begin
            cur_speed <= run ? target_speed : '0;
            st        <= (run && target_speed != '0) ? CRUISE : IDLE;
        end
    end
`endif

endmodule

// File: tb/tb_bg_scroller.sv
// tb_bg_scroller -- directed self-checking bench for bg_scroller with
// default parameters (160x240, 2 layers, 4.4 fixed point, step 2).
module tb_bg_scroller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_end = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  target_speed = 8'h00;
    logic [7:0]  drift_x = 8'h00;
    logic [19:0] offset_x, offset_y;
    logic [7:0]  cur_speed;
    logic [1:0]  state;

    int n_assert = 0;
    int n_fail   = 0;

    bg_scroller dut (
        .clk          (clk),
        .reset        (reset),
        .frame_end    (frame_end),
        .run          (run),
        .clear        (clear),
        .target_speed (target_speed),
        .drift_x      (drift_x),
        .offset_x     (offset_x),
        .offset_y     (offset_y),
        .cur_speed    (cur_speed),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse frame_end (optionally with clear) for one clock; returns at a
    // falling edge so outputs are stable for sampling.
    task automatic frame(input logic clr);
        @(negedge clk);
        frame_end = 1'b1;
        clear     = clr;
        @(negedge clk);
        frame_end = 1'b0;
        clear     = 1'b0;
    endtask

    function automatic logic [31:0] pair(input int l1, input int l0);
        logic [19:0] v;
        v = {10'(l1), 10'(l0)};
        return 32'(v);
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_speed", 32'(cur_speed), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_offy", 32'(offset_y), 0);
        chk("rst_offx", 32'(offset_x), 0);
        @(negedge clk);
        reset = 1'b1;

`ifdef BG_SCROLL_RAMP_EN
        // Ramp 0 -> 0x10 in steps of 2
        run = 1'b1; target_speed = 8'h10;
        for (int i = 1; i <= 8; i++) begin
            frame(1'b0);
            chk("ramp_speed", 32'(cur_speed), 32'(2 * i));
        end
        chk("ramp_cruise", 32'(state), 2);
        // Cruise at 1 px/frame from zero
        @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;
        chk("clear_only", 32'(offset_y), 0);
        frame(1'b0);
        chk("cruise_y1", 32'(offset_y), pair(239, 239));
        frame(1'b0);
        chk("cruise_y2", 32'(offset_y), pair(239, 238));
        // clear wins over frame_end, speed held
        frame(1'b1);
        chk("clr_offy", 32'(offset_y), 0);
        chk("clr_speed", 32'(cur_speed), 32'h10);
        chk("clr_state", 32'(state), 2);
        // Brake: 16 -> 0 over 8 frames, total motion 72/16 px
        run = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            frame(1'b0);
            chk("brake_speed", 32'(cur_speed), 32'(16 - 2 * i));
        end
        chk("brake_idle", 32'(state), 0);
        chk("brake_offy0", 32'(offset_y[9:0]), 235);
        frame(1'b0);
        chk("frozen_offy0", 32'(offset_y[9:0]), 235);
        // Reset mid-ramp, off the clock edge
        run = 1'b1;
        frame(1'b0);
        frame(1'b0);
        chk("mid_ramp", 32'(state), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_speed", 32'(cur_speed), 0);
        chk("async_state", 32'(state), 0);
        chk("async_offy", 32'(offset_y), 0);
        @(negedge clk); reset = 1'b1;
        frame(1'b0);
        chk("post_rst_speed", 32'(cur_speed), 2);
        chk("post_rst_state", 32'(state), 1);
`else
        // Direct load: speed appears after the first frame, motion one later
        run = 1'b1; target_speed = 8'h20;
        frame(1'b0);
        chk("load_speed", 32'(cur_speed), 32'h20);
        chk("load_state", 32'(state), 2);
        chk("latency_offy", 32'(offset_y), 0);
        frame(1'b0);
        chk("wrap_offy", 32'(offset_y), pair(239, 238));
        chk("wrap_offx0", 32'(offset_x), 0);
        // Horizontal drift applies immediately
        drift_x = 8'h30;
        frame(1'b0);
        chk("drift_offx", 32'(offset_x), pair(158, 157));
        chk("drift_offy", 32'(offset_y), pair(238, 236));
        // run toggled between frames is ignored
        @(negedge clk); run = 1'b0;
        repeat (3) @(negedge clk);
        chk("run_toggle_speed", 32'(cur_speed), 32'h20);
        chk("run_toggle_state", 32'(state), 2);
        chk("no_frame_hold", 32'(offset_y), pair(238, 236));
        run = 1'b1;
        // clear + frame_end: offsets zero, speed not reloaded
        target_speed = 8'h40;
        frame(1'b1);
        chk("clr_offy", 32'(offset_y), 0);
        chk("clr_offx", 32'(offset_x), 0);
        chk("clr_speed", 32'(cur_speed), 32'h20);
        frame(1'b0);
        chk("reload_speed", 32'(cur_speed), 32'h40);
        chk("old_speed_offy", 32'(offset_y), pair(239, 238));
        chk("old_speed_offx", 32'(offset_x), pair(158, 157));
        // Maximum speed
        target_speed = 8'hFF;
        frame(1'b0);
        chk("max_speed", 32'(cur_speed), 32'hFF);
        chk("max_prev_offy", 32'(offset_y), pair(237, 234));
        chk("max_prev_offx", 32'(offset_x), pair(157, 154));
        run = 1'b0;
        frame(1'b0);
        chk("stop_speed", 32'(cur_speed), 0);
        chk("stop_state", 32'(state), 0);
        chk("max_offy", 32'(offset_y), pair(229, 218));
        chk("max_offx", 32'(offset_x), pair(155, 151));
        drift_x = 8'h00;
        frame(1'b0);
        chk("idle_frozen_y", 32'(offset_y), pair(229, 218));
        chk("idle_frozen_x", 32'(offset_x), pair(155, 151));
        // Async reset away from the clock edge
        run = 1'b1;
        frame(1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_speed", 32'(cur_speed), 0);
        chk("async_state", 32'(state), 0);
        chk("async_offy", 32'(offset_y), 0);
        chk("async_offx", 32'(offset_x), 0);
        @(negedge clk); reset = 1'b1;
        target_speed = 8'h20;
        frame(1'b0);
        chk("post_rst_speed", 32'(cur_speed), 32'h20);
        chk("post_rst_state", 32'(state), 2);
        chk("post_rst_offy", 32'(offset_y), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard stop in case a wait ever hangs.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
